tablero_jugadas: RTL

Board-state and turn controller for the tic-tac-toe datapath. It accepts move requests, validates them, and holds the 9-cell board register that feeds the row, column and diagonal winner-check stage directly downstream. It samples that stage's combinational verdict one cycle after each write. It alternates turns and reports win, draw and game-over to the display and top level.

---
 rtl/juego_pkg.sv | 29 ++
 rtl/decod_celda.sv | 12 +
 rtl/tablero_jugadas.sv | 136 +++++++++++++
 3 files changed

// File: rtl/juego_pkg.sv
// Shared codes for the tic-tac-toe datapath: cell contents, game results
// and the board controller state encoding.
package juego_pkg;

    localparam logic [1:0] CELDA_VACIA = 2'b00;
    localparam logic [1:0] JUG1        = 2'b01;
    localparam logic [1:0] JUG2        = 2'b10;

    localparam int unsigned NUM_CELDAS = 9;

    typedef enum logic [1:0] {
        RES_NINGUNO = 2'b00,
        RES_J1      = 2'b01,
        RES_J2      = 2'b10,
        RES_EMPATE  = 2'b11
    } res_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        CHECK = 2'b10,
        DONE  = 2'b11
    } estado_e;

    function automatic logic [1:0] rival(input logic [1:0] jugador);
        return (jugador == JUG1) ? JUG2 : JUG1;
    endfunction

endpackage

// File: rtl/decod_celda.sv
// Cell index decoder: 4-bit row-major index to a one-hot write enable,
// with a flag for indices 9..15 (which enable nothing).
module decod_celda (
    input  logic [3:0] idx_i,
    output logic [8:0] we_o,
    output logic       out_of_range_o
);

    assign out_of_range_o = (idx_i > 4'd8);
    assign we_o           = out_of_range_o ? 9'b0 : (9'b1 << idx_i);

endmodule

// File: rtl/tablero_jugadas.sv
// Board register and turn controller: validates moves, writes the board,
// samples the external winner checker and reports win / draw / game over.
module tablero_jugadas
    import juego_pkg::*;
#(
    parameter logic [1:0] FIRST_PLAYER = JUG1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    output logic        move_ready,
    output logic        move_ack,
    output logic        move_err,
    output logic [17:0] board,
    output logic [1:0]  turn,
    output logic [3:0]  move_count,
    input  logic        win_in,
    input  logic [1:0]  win_player_in,
    output logic        game_over,
    output logic [1:0]  result
);

    estado_e     state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [1:0]  turn_q, turn_d;
    logic [3:0]  count_q, count_d;
    res_e        result_q, result_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic [8:0]  we;
    logic [8:0]  ocupada;
    logic        fuera_rango;
    logic        legal;

    decod_celda u_decod (
        .idx_i          (move_pos),
        .we_o           (we),
        .out_of_range_o (fuera_rango)
    );

    always_comb begin
        for (int i = 0; i < NUM_CELDAS; i++) begin
            ocupada[i] = (board_q[2*i +: 2] != CELDA_VACIA);
        end
    end

    assign legal = !fuera_rango && ((we & ocupada) == 9'b0);

    always_comb begin
        // NOTE: every target gets its hold value first, so no path leaves a variable unassigned and no latch is inferred.
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        count_d  = count_q;
        result_d = result_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;

        if (start) begin
            // A move on the same edge as start is dropped without ack or err.
            state_d  = PLAY;
            board_d  = '0;
            turn_d   = FIRST_PLAYER;
            count_d  = '0;
            result_d = RES_NINGUNO;
        end else begin
            unique case (state_q)
                PLAY: begin
                    if (move_valid) begin
                        if (legal) begin
                            for (int i = 0; i < NUM_CELDAS; i++) begin
                                if (we[i]) board_d[2*i +: 2] = turn_q;
                            end
                            count_d = count_q + 4'd1;
                            ack_d   = 1'b1;
                            state_d = CHECK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    err_d = move_valid;
                    // A verdict naming anyone but the player who just moved is a checker fault.
                    if (win_in && (win_player_in == turn_q)) begin
                        result_d = res_e'(win_player_in);
                        state_d  = DONE;
                    end else if (count_q == 4'd9) begin
                        result_d = RES_EMPATE;
                        state_d  = DONE;
                    end else begin
                        turn_d  = rival(turn_q);
                        state_d = PLAY;
                    end
                end
                default: begin
                    err_d = move_valid;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            board_q  <= '0;
            turn_q   <= CELDA_VACIA;
            count_q  <= '0;
            result_q <= RES_NINGUNO;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            turn_q   <= turn_d;
            count_q  <= count_d;
            result_q <= result_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign move_ready = (state_q == PLAY);
    assign game_over  = (state_q == DONE);
    assign turn       = (state_q == PLAY) ? turn_q : CELDA_VACIA;
    assign board      = board_q;
    assign move_count = count_q;
    assign result     = result_q;
    assign move_ack   = ack_q;
    assign move_err   = err_q;

endmodule
